// File: rtl/tdc_decoder_if.sv
// tdc_decoder_if: sample/result bundle between the delay-line front end and
// the phase decoder.
//   master: drives en, therm, missed_fb; observes the decoded results.
//   slave : consumes the snapshot; drives out/out_valid/sat/bubble,
//           avg/avg_valid and locked.
interface tdc_decoder_if #(
  parameter int NTAPS = 64,
  parameter int OUT_W = 8
);
  logic                    en;
  logic [NTAPS-1:0]        therm;
  logic                    missed_fb;
  logic signed [OUT_W-1:0] out;
  logic                    out_valid;
  logic                    sat;
  logic                    bubble;
  logic signed [OUT_W-1:0] avg;
  logic                    avg_valid;
  logic                    locked;

  modport master (
    output en, therm, missed_fb,
    input  out, out_valid, sat, bubble, avg, avg_valid, locked
  );

  modport slave (
    input  en, therm, missed_fb,
    output out, out_valid, sat, bubble, avg, avg_valid, locked
  );
endinterface

// File: rtl/tdc_decoder.sv
// tdc_decoder: PLL phase-detector back end. Turns a delay-line thermometer
// snapshot into a signed, saturating phase code centred on zero, flags
// bubbles and missed feedback edges, and keeps a boxcar average plus a
// lock indicator.
//   refclk : sole clock, rising edge
//   reset  : synchronous, active high
//   bus    : tdc_decoder_if.slave (en/therm/missed_fb in; out, out_valid,
//            sat, bubble, avg, avg_valid, locked out)
// Pipeline: capture (edge N) -> encode k/bubble (N+1) -> code/sat (N+2)
//           -> average and lock state (N+3).
module tdc_decoder #(
  parameter int NTAPS       = 64,
  parameter int OUT_W       = 8,
  parameter int AVG_LOG2    = 2,
  parameter int LOCK_THRESH = 2,
  parameter int LOCK_CYCLES = 16
) (
  input logic          refclk,
  input logic          reset,
  tdc_decoder_if.slave bus
);
  localparam int R      = NTAPS / 2;
  localparam int KW     = $clog2(NTAPS + 1);
  localparam int WIN    = 1 << AVG_LOG2;
  localparam int SUM_W  = OUT_W + AVG_LOG2;
  localparam int FILL_W = AVG_LOG2 + 1;
  localparam int CNT_W  = $clog2(LOCK_CYCLES + 1);
  localparam int STAGES = 2;

  typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} lock_state_t;

  // vld_pipe[0]: captured, [1]: encoded, [2]: out_valid
  logic [STAGES:0]         vld_pipe;
  logic [NTAPS-1:0]        cap_therm;
  logic                    cap_miss;

  logic [KW-1:0]           enc_k;
  logic                    enc_bub;
  logic [KW-1:0]           k_q;
  logic                    bub_q;
  logic                    miss_q;

  logic signed [OUT_W-1:0] out_q;
  logic                    sat_q;
  logic                    bubble_q;
  logic                    out_miss_q;

  logic signed [OUT_W-1:0] win [WIN];
  logic signed [SUM_W-1:0] sum;
  logic [FILL_W-1:0]       fill;
  logic                    avg_valid_q;

  lock_state_t             state, state_n;
  logic [CNT_W-1:0]        cnt, cnt_n;
  logic [OUT_W-1:0]        mag;
  logic                    in_win;

  // Capture: the snapshot only moves when en is high.
  always_ff @(posedge refclk) begin
    if (reset) begin
      vld_pipe  <= '0;
      cap_therm <= '0;
      cap_miss  <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], bus.en};
      if (bus.en) begin
        cap_therm <= bus.therm;
        cap_miss  <= bus.missed_fb;
      end
    end
  end

  // k = lowest zero tap; any 1 above it is a bubble and is ignored.
  // A missed edge is reported as fully late: k = NTAPS, no bubble.
  always_comb begin
    enc_k   = KW'(NTAPS);
    enc_bub = 1'b0;
    for (int i = NTAPS - 1; i >= 0; i--)
      if (!cap_therm[i]) enc_k = KW'(i);
    for (int i = 0; i < NTAPS; i++)
      if (cap_therm[i] && (KW'(i) > enc_k)) enc_bub = 1'b1;
    if (cap_miss) begin
      enc_k   = KW'(NTAPS);
      enc_bub = 1'b0;
    end
  end

  always_ff @(posedge refclk) begin
    if (reset) begin
      k_q    <= '0;
      bub_q  <= 1'b0;
      miss_q <= 1'b0;
    end else if (vld_pipe[0]) begin
      k_q    <= enc_k;
      bub_q  <= enc_bub;
      miss_q <= cap_miss;
    end
  end

  // Output stage: results hold between valid strobes.
  always_ff @(posedge refclk) begin
    if (reset) begin
      out_q      <= '0;
      sat_q      <= 1'b0;
      bubble_q   <= 1'b0;
      out_miss_q <= 1'b0;
    end else if (vld_pipe[1]) begin
      out_q      <= OUT_W'(k_q) - OUT_W'(R);
      sat_q      <= (k_q == '0) || (k_q == KW'(NTAPS));
      bubble_q   <= bub_q;
      out_miss_q <= miss_q;
    end
  end

  // Boxcar: running sum over the last WIN codes; the window starts zeroed
  // so the sum is exact from the first sample.
  always_ff @(posedge refclk) begin
    if (reset) begin
      for (int i = 0; i < WIN; i++) win[i] <= '0;
      sum         <= '0;
      fill        <= '0;
      avg_valid_q <= 1'b0;
    end else if (vld_pipe[2]) begin
      win[0] <= out_q;
      for (int i = 1; i < WIN; i++) win[i] <= win[i-1];
      sum <= sum + SUM_W'(out_q) - SUM_W'(win[WIN-1]);
      if (!avg_valid_q) begin
        fill <= fill + 1'b1;
        if (fill == FILL_W'(WIN - 1)) avg_valid_q <= 1'b1;
      end
    end
  end

  // Lock FSM
  assign mag    = out_q[OUT_W-1] ? OUT_W'(-out_q) : OUT_W'(out_q);
  assign in_win = !out_miss_q && (mag <= OUT_W'(LOCK_THRESH));

  always_ff @(posedge refclk) begin
    if (reset) begin
      state <= UNLOCKED;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (vld_pipe[2]) begin
      if (!in_win) begin
        state_n = UNLOCKED;
        cnt_n   = '0;
      end else begin
        if (cnt != CNT_W'(LOCK_CYCLES)) cnt_n = cnt + 1'b1;
        state_n = (cnt_n == CNT_W'(LOCK_CYCLES)) ? LOCKED : ACQUIRE;
      end
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = vld_pipe[STAGES];
  assign bus.sat       = sat_q;
  assign bus.bubble    = bubble_q;
  assign bus.avg       = OUT_W'(sum >>> AVG_LOG2);
  assign bus.avg_valid = avg_valid_q;
  assign bus.locked    = (state == LOCKED);
endmodule

// File: tb/tb_tdc_decoder.sv
module tb_tdc_decoder;
  logic refclk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  tdc_decoder_if #(.NTAPS(64), .OUT_W(8)) bus ();

  tdc_decoder dut (.refclk(refclk), .reset(reset), .bus(bus));

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  typedef struct {
    logic signed [7:0] code;
    logic              sat;
    logic              bub;
    int                due;
  } exp_t;

  exp_t q[$];
  logic signed [7:0] last_out = '0;
  logic              last_sat = 1'b0;
  logic              last_bub = 1'b0;

  // Scoreboard monitor: samples 1 time unit after each rising edge.
  always @(posedge refclk) begin
    exp_t e;
    cyc = cyc + 1;
    #1;
    if (reset) begin
      checks++;
      if (bus.out_valid !== 1'b0 || bus.out !== 8'sd0 || bus.sat !== 1'b0 || bus.bubble !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs: valid=%b out=%0d sat=%b bub=%b required 0/0/0/0",
                 bus.out_valid, bus.out, bus.sat, bus.bubble);
      end
      last_out = '0; last_sat = 1'b0; last_bub = 1'b0;
    end else if (bus.out_valid) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: out_valid=1 out=%0d at cycle %0d, required no strobe", bus.out, cyc);
      end else begin
        e = q.pop_front();
        if (cyc !== e.due || bus.out !== e.code || bus.sat !== e.sat || bus.bubble !== e.bub) begin
          errors++;
          $display("FAIL sample: cyc=%0d out=%0d sat=%b bub=%b, required cyc=%0d out=%0d sat=%b bub=%b",
                   cyc, bus.out, bus.sat, bus.bubble, e.due, e.code, e.sat, e.bub);
        end
      end
      last_out = bus.out; last_sat = bus.sat; last_bub = bus.bubble;
    end else begin
      checks++;
      if (bus.out !== last_out || bus.sat !== last_sat || bus.bubble !== last_bub) begin
        errors++;
        $display("FAIL hold: out=%0d sat=%b bub=%b, required %0d/%b/%b",
                 bus.out, bus.sat, bus.bubble, last_out, last_sat, last_bub);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] ones(input int n);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i] = 1'b1;
    return v;
  endfunction

  task automatic send(input logic [63:0] th, input logic miss,
                      input logic signed [7:0] ec, input logic es, input logic eb);
    exp_t e;
    @(negedge refclk);
    bus.en = 1'b1; bus.therm = th; bus.missed_fb = miss;
    e.code = ec; e.sat = es; e.bub = eb; e.due = cyc + 3;
    q.push_back(e);
  endtask

  // n low ones, no bubble, no miss: code n-32
  task automatic sendc(input int n);
    send(ones(n), 1'b0, 8'(n - 32), (n == 0 || n == 64), 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge refclk);
      bus.en = 1'b0; bus.missed_fb = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge refclk);
    reset = 1'b1; bus.en = 1'b0; bus.missed_fb = 1'b0;
    q.delete();
    @(negedge refclk);
    reset = 1'b0;
  endtask

  task automatic drain(input string name);
    idle(4);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d samples never produced out_valid, required 0", name, q.size());
    end
    q.delete();
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if (bus.out !== 8'sd0 || bus.out_valid !== 1'b0 || bus.sat !== 1'b0 || bus.bubble !== 1'b0 ||
        bus.avg !== 8'sd0 || bus.avg_valid !== 1'b0 || bus.locked !== 1'b0) begin
      errors++;
      $display("FAIL %s: out=%0d v=%b sat=%b bub=%b avg=%0d avg_v=%b lock=%b, required all 0", name,
               bus.out, bus.out_valid, bus.sat, bus.bubble, bus.avg, bus.avg_valid, bus.locked);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge refclk);
    check_reset_values("reset_state");
    reset = 1'b0;
  endtask

  task automatic test_codes();
    logic [63:0] b;
    b = ones(10); b[12] = 1'b1;
    do_reset();
    send(ones(32), 1'b0,  8'sd0,  1'b0, 1'b0);
    send(ones(40), 1'b0,  8'sd8,  1'b0, 1'b0);
    send(b,        1'b0, -8'sd22, 1'b0, 1'b1);
    send('0,       1'b0, -8'sd32, 1'b1, 1'b0);
    send(ones(64), 1'b0,  8'sd32, 1'b1, 1'b0);
    send(ones(32), 1'b1,  8'sd32, 1'b1, 1'b0);
    send(b,        1'b1,  8'sd32, 1'b1, 1'b0);
    send(b,        1'b0, -8'sd22, 1'b0, 1'b1);
    send(ones(33), 1'b0,  8'sd1,  1'b0, 1'b0);
    drain("codes");
  endtask

  task automatic test_avg();
    do_reset();
    sendc(36); sendc(36); sendc(40); sendc(40);
    idle(3);
    checks++;
    if (bus.avg_valid !== 1'b0) begin
      errors++; $display("FAIL avg_valid_early: got %b required 0", bus.avg_valid);
    end
    idle(1);
    checks++;
    if (bus.avg_valid !== 1'b1 || bus.avg !== 8'sd6) begin
      errors++; $display("FAIL avg_pos: avg=%0d valid=%b required 6/1", bus.avg, bus.avg_valid);
    end
    sendc(31); sendc(31); sendc(31); sendc(30);
    idle(4);
    checks++;
    if (bus.avg_valid !== 1'b1 || bus.avg !== -8'sd2) begin
      errors++; $display("FAIL avg_neg: avg=%0d valid=%b required -2/1", bus.avg, bus.avg_valid);
    end
    drain("avg");
  endtask

  task automatic test_lock();
    do_reset();
    for (int i = 0; i < 16; i++) sendc(33);
    idle(3);
    checks++;
    if (bus.locked !== 1'b0) begin
      errors++; $display("FAIL lock_early: got %b required 0", bus.locked);
    end
    idle(1);
    checks++;
    if (bus.locked !== 1'b1) begin
      errors++; $display("FAIL lock_rise: got %b required 1", bus.locked);
    end
    sendc(37);
    idle(3);
    checks++;
    if (bus.locked !== 1'b1) begin
      errors++; $display("FAIL lock_hold: got %b required 1", bus.locked);
    end
    idle(1);
    checks++;
    if (bus.locked !== 1'b0) begin
      errors++; $display("FAIL lock_fall: got %b required 0", bus.locked);
    end
    drain("lock");
  endtask

  task automatic test_missed_lock();
    do_reset();
    for (int i = 0; i < 15; i++) sendc(30 + (i % 5));
    send(ones(32), 1'b1, 8'sd32, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      idle(1);
      checks++;
      if (bus.locked !== 1'b0) begin
        errors++; $display("FAIL missed_lock: locked=%b at idle %0d required 0", bus.locked, i);
      end
    end
    drain("missed_lock");
  endtask

  task automatic test_enable_gaps();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      sendc(28 + 3 * i);
      idle(1 + (i % 2));
    end
    drain("gaps");
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++) sendc(40);
    idle(5);
    checks++;
    if (bus.avg_valid !== 1'b1 || bus.avg !== 8'sd8) begin
      errors++; $display("FAIL pre_reset_avg: avg=%0d valid=%b required 8/1", bus.avg, bus.avg_valid);
    end
    sendc(36);
    sendc(38);
    @(negedge refclk);
    reset = 1'b1; bus.en = 1'b0;
    q.delete();
    @(negedge refclk);
    reset = 1'b0;
    check_reset_values("reset_mid_values");
    idle(6);
    sendc(34); sendc(34); sendc(34);
    idle(4);
    checks++;
    if (bus.avg_valid !== 1'b0) begin
      errors++; $display("FAIL avg_refill_early: got %b required 0", bus.avg_valid);
    end
    sendc(34);
    idle(4);
    checks++;
    if (bus.avg_valid !== 1'b1 || bus.avg !== 8'sd2) begin
      errors++; $display("FAIL avg_refill: avg=%0d valid=%b required 2/1", bus.avg, bus.avg_valid);
    end
    drain("reset_mid");
  endtask

  task automatic test_reset_with_en();
    do_reset();
    @(negedge refclk);
    reset = 1'b1; bus.en = 1'b1; bus.therm = ones(40);
    @(negedge refclk);
    reset = 1'b0; bus.en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge refclk);
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++; $display("FAIL reset_with_en: out_valid=%b at cycle %0d required 0", bus.out_valid, i);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.en = 1'b0;
    bus.therm = '0;
    bus.missed_fb = 1'b0;
    test_reset();
    test_codes();
    test_avg();
    test_lock();
    test_missed_lock();
    test_enable_gaps();
    test_reset_mid();
    test_reset_with_en();
    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tdc_decoder.md
# tdc_decoder

Parametrised, synthesizable phase-detector back end for the PLL loop. It samples a delay-line thermometer snapshot of the feedback edge on every reference edge. It converts the snapshot to a signed, saturating phase code centred on zero and flags missed feedback edges. It also provides a boxcar-averaged code and a lock indicator for the loop filter and the control logic.

## Interface
Parameters:
- `NTAPS`, 64: delay-line taps. Even, ≥4. Single-sided range `R = NTAPS/2` LSBs.
- `OUT_W`, 8: signed code width. Must satisfy `OUT_W ≥ $clog2(NTAPS)+1`.
- `AVG_LOG2`, 2: averaging window is `2^AVG_LOG2` samples. Range 0..4.
- `LOCK_THRESH`, 2: lock window, in LSBs, on `|code|`.
- `LOCK_CYCLES`, 16: consecutive in-window samples required to declare lock. Must be ≥1.

Ports:
- `refclk`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `en`  in  1  sample qualifier; the snapshot is consumed only when high.
- `therm`  in  NTAPS  delay-line snapshot. Bit `i`=1 means the feedback edge had reached tap `i`.
- `missed_fb`  in  1  no feedback edge since the previous reference edge.
- `out`  out  OUT_W  signed phase code.
- `out_valid`  out  1  single-cycle strobe qualifying `out`/`sat`.
- `sat`  out  1  `|out| == R` or missed feedback.
- `bubble`  out  1  snapshot contained a 1 above the first 0.
- `avg`  out  OUT_W  signed window average.
- `avg_valid`  out  1  window full since reset.
- `locked`  out  1  lock indicator.

## Operation
- **Stage 1 (capture):** on `en`=1, register `therm` and `missed_fb`. On `en`=0, the stage holds and no valid token advances.
- **Stage 2 (encode):**
  - `k` = index of the lowest 0 in `therm`. `k = NTAPS` when all bits are 1.
  - Bits above `k` are ignored. `bubble` = OR of those bits.
  - `code = k − R`. Range `[−R, +R]`, exact with no rounding.
- **Missed feedback:** `missed_fb`=1 overrides the snapshot. `code = +R`, `sat`=1, `bubble`=0. The edge is treated as late and out of range.
- **`sat`:** asserts when `code == ±R`.
- **Averager:**
  - Shift register of the last `2^AVG_LOG2` codes plus a running sum of width `OUT_W+AVG_LOG2`.
  - Sum update: `sum += new − oldest`.
  - `avg = sum >>> AVG_LOG2`, arithmetic shift, rounding toward −∞.
  - `avg_valid` sets after `2^AVG_LOG2` valid codes and stays set until reset.
- **Lock FSM:**
  - States: UNLOCKED, ACQUIRE, LOCKED. Counter width `$clog2(LOCK_CYCLES+1)`.
  - From any state, a valid code with `|code| > LOCK_THRESH`, or with `missed_fb`, goes to UNLOCKED and clears the counter.
  - A valid in-window code increments the counter, saturating at `LOCK_CYCLES`. The state is ACQUIRE while the counter is below `LOCK_CYCLES`, and LOCKED when it reaches it.
  - `locked` = (state == LOCKED).
  - Non-valid cycles leave the state unchanged.

## Timing
- **Reset values:** `out`=0, `out_valid`=0, `sat`=0, `bubble`=0, `avg`=0, `avg_valid`=0, `locked`=0. Window, sum and counter are 0. FSM is in UNLOCKED.
- **Latency:** sample at edge N with `en`=1 produces `out`/`out_valid`/`sat`/`bubble` after edge N+2. `avg` and `locked` reflect that sample after edge N+3.
- **Throughput:** one sample per cycle. `out_valid` pulses once per accepted sample.
- **Hold:** `out`, `sat` and `bubble` hold their last values while `out_valid`=0.
- **Reset mid-operation:** in-flight samples are dropped. The first `out_valid` after reset needs a fresh `en` sample two cycles later.
- **Reset with `en`=1 in the same cycle:** reset wins and the sample is discarded.
- **Back-to-back sat/bubble:** each sample is flagged independently. Flags are not sticky.

## Test plan
- **Centre, in-range and bubble codes** (`NTAPS`=64): `therm` = low 32 ones → `out`=0, `sat`=0. Low 40 ones → `out`=+8. Low 10 ones plus bit 12 set → `out`=−22, `bubble`=1.
- **Saturation:** `therm`=0 → `out`=−32, `sat`=1. All ones → `out`=+32, `sat`=1. `missed_fb`=1 with `therm` at 32 ones → `out`=+32, `sat`=1, `bubble`=0.
- **Averaging** (`AVG_LOG2`=2): codes 4, 4, 8, 8 → `avg`=6 and `avg_valid` rises with the 4th sample. Then −1, −1, −1, −2 → `avg`=−2 (floor of −1.25).
- **Lock:** 16 consecutive codes of +1 → `locked` rises 3 cycles after the 16th sample. A following code of +5 → `locked` falls. 15 in-window codes then `missed_fb` → `locked` never asserts.
- **Enable gaps:** alternating `en` → `out_valid` pulses only for accepted samples with latency 2. `out` holds between pulses.
- **Reset mid-stream:** assert `reset` for 1 cycle with two samples in flight → no `out_valid` for them. All outputs read reset values. `avg_valid` re-requires 4 samples.
